seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed scanner for a common-anode multi-digit seven-segment display. It holds a displayed value, scans one digit slot at a time, and presents that digit's 4-bit nibble to the downstream hex-to-segment decoder via `digit_sel`. It also drives the active-low digit anodes and decimal point. New values are double-buffered and take effect only at frame boundaries, so the display never tears. Each slot begins with an anti-ghosting blank interval.

## Interface
- `NUM_DIGITS`, default 4: number of digits, legal range 1..8. Digit 0 is least significant and is scanned first.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all anodes off. Constraint: 1 <= `BLANK_CYCLES` < `REFRESH_DIV`.
- `clk`  in  1  system clock; the block has a single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `value_in`  in  4*NUM_DIGITS  hex value to display; nibble k belongs to digit k.
- `dp_in`  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- `value_valid`  in  1  single-cycle load strobe that captures `value_in` and `dp_in`.
- `blank_lz`  in  1  leading-zero suppression enable; static configuration, sampled at each slot start.
- `digit_sel`  out  4  nibble of the current digit, feeds the decoder's select input.
- `dp_n`  out  1  active-low decimal point; the top level substitutes it for segment bit 7 of the decoder output.
- `an_n`  out  NUM_DIGITS  active-low anode enables; at most one bit is low at any time.
- `frame_start`  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Registers:
  - pending buffer: value plus dp, with a `pending` flag;
  - shadow buffer: the value and dp actually displayed;
  - slot counter: 0..REFRESH_DIV-1;
  - `digit_idx`: 0..NUM_DIGITS-1;
  - FSM.
- FSM states:
  - S_BLANK: `an_n` all ones, `dp_n`=1.
  - S_DRIVE: `an_n[digit_idx]`=0, unless the digit is suppressed.
- Transitions:
  - S_BLANK → S_DRIVE when the slot counter = BLANK_CYCLES-1.
  - S_DRIVE → S_BLANK when the slot counter = REFRESH_DIV-1. On this transition the counter clears and `digit_idx` increments, wrapping from NUM_DIGITS-1 to 0.
- Slot length is exactly REFRESH_DIV cycles. Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- Load: `value_valid`=1 writes `value_in`/`dp_in` into the pending buffer and sets `pending`. A later strobe within the same frame overwrites the pending buffer; the latest value wins.
- Frame boundary: the edge where `digit_idx` wraps to 0.
  - If `pending`=1, the shadow buffer takes the pending buffer and `pending` clears.
  - If `value_valid` is asserted on the boundary edge itself, the incoming `value_in`/`dp_in` go directly to the shadow buffer and `pending` clears.
- `digit_sel` = shadow nibble[`digit_idx`] in both states. It is stable for the whole slot, giving the decoder the full blank interval to settle.
- `dp_n` = ~shadow dp[`digit_idx`] in S_DRIVE, 1 in S_BLANK.
- Leading-zero suppression: when `blank_lz`=1, digit k (k ≥ 1) is suppressed if shadow nibbles k..NUM_DIGITS-1 are all zero. A suppressed digit keeps `an_n` all ones and `dp_n`=1 for its whole slot. Digit 0 is never suppressed, so a value of 0 displays a single "0".
- Reset (asynchronous, takes effect immediately, mid-slot included):
  - `an_n` all ones, `digit_sel`=0, `dp_n`=1, `frame_start`=0;
  - FSM = S_BLANK, counter=0, `digit_idx`=0;
  - shadow=0, pending buffer=0, `pending`=0.
- After reset release, the first slot is digit 0, and `frame_start` pulses on the first clock edge.

## Timing
- All outputs are registered and update on the same edge as FSM and counter changes. There is no combinational path from any input to any output.
- Load-to-display latency: from the `value_valid` edge to the next frame boundary, at most NUM_DIGITS*REFRESH_DIV cycles.
- `frame_start` is high for exactly the first cycle of digit 0's S_BLANK phase.
- Anode overlap is impossible: every change of `an_n` passes through at least BLANK_CYCLES cycles with all anodes off.

## Test plan
Parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

1. Reset behaviour: after release, observe digit 0's slot, then assert `rst_n`=0 mid-drive. Required: `an_n`=1111, `dp_n`=1, `digit_sel`=0 without waiting for a clock edge. After release, 2 cycles with `an_n`=1111, then 6 cycles with `an_n`=1110, and `frame_start` high on the first cycle.
2. Mid-frame load: pulse `value_valid` with `value_in`=16'h12AB during digit 1's slot. Required: `digit_sel`=0 for the rest of the frame. The next frame shows B, A, 2, 1 with `an_n`=1110, 1101, 1011, 0111, each driven for 6 cycles.
3. Leading-zero suppression: with `blank_lz`=1, load 16'h0050. Required: digit 3 and digit 2 slots keep `an_n`=1111 throughout, digit 1 shows 5, and digit 0 shows 0. Load 16'h0000: only digit 0 is driven, showing 0.
4. Overwrite within a frame: two strobes in one frame, 16'h1111 then 16'h2222. Required: the next frame shows 2222, and 1111 never appears.
5. Strobe on the boundary: with 16'h1111 pending, strobe 16'h3333 exactly on the wrap edge. Required: the new frame shows 3333, and `pending`=0 afterwards.
6. Decimal point: load `dp_in`=4'b0100. Required: `dp_n`=0 only during digit 2's drive phase (6 cycles per frame); `dp_n`=1 during every blank phase and every other slot.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display. Values are
// double-buffered and swap in only at frame boundaries; each slot opens with a blank.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    value_valid,
  input  logic                    blank_lz,
  output logic [3:0]              digit_sel,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic                  armed_r;
  logic [VW-1:0]         pend_val_r;
  logic [NUM_DIGITS-1:0] pend_dp_r;
  logic                  pending_r;
  logic                  pending_nxt_s;
  logic [VW-1:0]         shadow_val_r;
  logic [VW-1:0]         shadow_val_nxt_s;
  logic [NUM_DIGITS-1:0] shadow_dp_r;
  logic [NUM_DIGITS-1:0] shadow_dp_nxt_s;
  logic                  supp_r;
  logic                  supp_nxt_s;
  logic                  slot_end_s;
  logic                  blank_end_s;
  logic                  boundary_s;
  logic                  slot_start_s;
  logic                  drive_nxt_s;

  function automatic logic [3:0] nibble_at(input logic [VW-1:0] v, input logic [IDX_W-1:0] idx);
    logic [3:0] n;
    n = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      n = (IDX_W'(k) == idx) ? v[4*k +: 4] : n;
    end
    return n;
  endfunction

  function automatic logic dp_at(input logic [NUM_DIGITS-1:0] dp, input logic [IDX_W-1:0] idx);
    logic d;
    d = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = (IDX_W'(k) == idx) ? dp[k] : d;
    end
    return d;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] m;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      m[k] = (IDX_W'(k) != idx);
    end
    return m;
  endfunction

  // Digit idx is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lz_suppressed(input logic [VW-1:0] v, input logic [IDX_W-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nz = nz | ((k >= int'(idx)) && (v[4*k +: 4] != 4'h0));
    end
    return (idx != IDX_W'(0)) && !nz;
  endfunction

  // Slot and frame events; the first edge after reset opens digit 0's slot
  always_comb begin
    slot_end_s   = armed_r && (state_r == S_DRIVE) && (cnt_r == CNT_LAST);
    blank_end_s  = armed_r && (state_r == S_BLANK) && (cnt_r == BLANK_LAST);
    boundary_s   = slot_end_s && (idx_r == IDX_LAST);
    slot_start_s = slot_end_s || !armed_r;
  end

  // Next FSM state, slot counter and digit index
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_BLANK: begin
        if (blank_end_s) state_nxt_s = S_DRIVE;
        else             state_nxt_s = S_BLANK;
      end
      S_DRIVE: begin
        if (slot_end_s) state_nxt_s = S_BLANK;
        else            state_nxt_s = S_DRIVE;
      end
      default: state_nxt_s = S_BLANK;
    endcase

    if (slot_start_s) cnt_nxt_s = {CNT_W{1'b0}};
    else              cnt_nxt_s = cnt_r + CNT_W'(1);

    if (boundary_s)      idx_nxt_s = {IDX_W{1'b0}};
    else if (slot_end_s) idx_nxt_s = idx_r + IDX_W'(1);
    else                 idx_nxt_s = idx_r;
  end

  // Shadow swap at the frame boundary; a strobe on that very edge bypasses pending
  always_comb begin
    shadow_val_nxt_s = shadow_val_r;
    shadow_dp_nxt_s  = shadow_dp_r;
    pending_nxt_s    = pending_r;
    if (boundary_s) begin
      pending_nxt_s = 1'b0;
      if (value_valid) begin
        shadow_val_nxt_s = value_in;
        shadow_dp_nxt_s  = dp_in;
      end else if (pending_r) begin
        shadow_val_nxt_s = pend_val_r;
        shadow_dp_nxt_s  = pend_dp_r;
      end else begin
        shadow_val_nxt_s = shadow_val_r;
        shadow_dp_nxt_s  = shadow_dp_r;
      end
    end else if (value_valid) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Suppression is decided once per slot, from the buffer that slot will show
  always_comb begin
    if (slot_start_s) supp_nxt_s = blank_lz && lz_suppressed(shadow_val_nxt_s, idx_nxt_s);
    else              supp_nxt_s = supp_r;
    drive_nxt_s = (state_nxt_s == S_DRIVE) && !supp_nxt_s;
  end

  // Pending buffer: latest strobe wins until the next boundary consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_r <= {VW{1'b0}};
      pend_dp_r  <= {NUM_DIGITS{1'b0}};
      pending_r  <= 1'b0;
    end else begin
      if (value_valid) begin
        pend_val_r <= value_in;
        pend_dp_r  <= dp_in;
      end
      pending_r <= pending_nxt_s;
    end
  end

  // Scan FSM, shadow buffer and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_BLANK;
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      armed_r      <= 1'b0;
      shadow_val_r <= {VW{1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      supp_r       <= 1'b0;
      digit_sel    <= 4'h0;
      dp_n         <= 1'b1;
      an_n         <= {NUM_DIGITS{1'b1}};
      frame_start  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      armed_r      <= 1'b1;
      shadow_val_r <= shadow_val_nxt_s;
      shadow_dp_r  <= shadow_dp_nxt_s;
      supp_r       <= supp_nxt_s;
      digit_sel    <= nibble_at(shadow_val_nxt_s, idx_nxt_s);
      dp_n         <= drive_nxt_s ? ~dp_at(shadow_dp_nxt_s, idx_nxt_s) : 1'b1;
      an_n         <= drive_nxt_s ? anode_mask(idx_nxt_s) : {NUM_DIGITS{1'b1}};
      frame_start  <= slot_start_s && (idx_nxt_s == {IDX_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: table vectors, hand-written corner sequences
// and randomized loads compared every cycle against a time-based reference model.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic        blank_lz;
  logic [3:0]  digit_sel;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .value_valid(value_valid),
    .blank_lz   (blank_lz),
    .digit_sel  (digit_sel),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  typedef struct {
    int          edge_no;
    logic [15:0] v;
    logic [3:0]  dp;
  } load_t;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] sel;   // expected digit_sel, nibble k for digit k
    logic [15:0] an;    // expected an_n during drive, nibble k for digit k
    logic [3:0]  dpn;   // expected dp_n during drive, bit k for digit k
  } vec_t;

  load_t loads[$];
  vec_t  vecs[6];
  int    edge_n;
  int    n_checks;
  int    n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s t=%0d actual=%0h required=%0h", name, edge_n - 1, act, req);
  endtask

  // Expected outputs for cycle t after reset release (t=0 starts at the first edge).
  // A load sampled at edge n is shown from the first frame whose opening edge is >= n.
  function automatic void model(input int t, output logic [3:0] sel, output logic [3:0] an,
                                output logic dpn, output logic fs);
    int f, idx, ph;
    logic [15:0] v;
    logic [3:0]  dp;
    logic supp, lit;
    f   = t / FR;
    idx = (t / RD) % ND;
    ph  = t % RD;
    v   = 16'h0;
    dp  = 4'h0;
    if (f > 0) begin
      foreach (loads[i]) begin
        if (loads[i].edge_no <= f * FR + 1) begin
          v  = loads[i].v;
          dp = loads[i].dp;
        end
      end
    end
    supp = blank_lz && (idx > 0) && ((v >> (4 * idx)) == 16'h0);
    lit  = (ph >= BC) && !supp;
    sel  = 4'((v >> (4 * idx)) & 16'hF);
    an   = lit ? ~(4'b0001 << idx) : 4'b1111;
    dpn  = lit ? ~dp[idx] : 1'b1;
    fs   = ((t % FR) == 0);
  endfunction

  // One clock: drive inputs, take the edge, then compare against the model at negedge.
  task automatic step(input logic vv, input logic [15:0] v, input logic [3:0] d);
    logic [3:0] es, ea;
    logic ed, ef;
    load_t ld;
    value_valid = vv;
    value_in    = v;
    dp_in       = d;
    @(posedge clk);
    edge_n++;
    if (vv) begin
      ld.edge_no = edge_n;
      ld.v       = v;
      ld.dp      = d;
      loads.push_back(ld);
    end
    @(negedge clk);
    value_valid = 1'b0;
    model(edge_n - 1, es, ea, ed, ef);
    check("digit_sel", 32'(digit_sel), 32'(es));
    check("an_n", 32'(an_n), 32'(ea));
    check("dp_n", 32'(dp_n), 32'(ed));
    check("frame_start", 32'(frame_start), 32'(ef));
  endtask

  task automatic run_to(input int t);
    while (edge_n - 1 < t) step(1'b0, 16'h0, 4'h0);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear immediately.
  task automatic do_reset(input logic lz);
    #3 rst_n = 1'b0;
    #1;
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_digit_sel", 32'(digit_sel), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    @(negedge clk);
    loads.delete();
    edge_n   = 0;
    blank_lz = lz;
    rst_n    = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    edge_n      = 0;
    rst_n       = 1'b1;
    value_in    = 16'h0;
    dp_in       = 4'h0;
    value_valid = 1'b0;
    blank_lz    = 1'b0;

    vecs[0] = '{v: 16'h12AB, dp: 4'b0000, lz: 1'b0, sel: 16'h12AB, an: 16'h7BDE, dpn: 4'b1111};
    vecs[1] = '{v: 16'h0050, dp: 4'b0000, lz: 1'b1, sel: 16'h0050, an: 16'hFFDE, dpn: 4'b1111};
    vecs[2] = '{v: 16'h0000, dp: 4'b0000, lz: 1'b1, sel: 16'h0000, an: 16'hFFFE, dpn: 4'b1111};
    vecs[3] = '{v: 16'h0000, dp: 4'b0000, lz: 1'b0, sel: 16'h0000, an: 16'h7BDE, dpn: 4'b1111};
    vecs[4] = '{v: 16'h4321, dp: 4'b0100, lz: 1'b0, sel: 16'h4321, an: 16'h7BDE, dpn: 4'b1011};
    vecs[5] = '{v: 16'h0700, dp: 4'b1000, lz: 1'b1, sel: 16'h0700, an: 16'hFBDE, dpn: 4'b1111};

    // Reset behaviour, including a reset asserted mid-drive with a lit digit
    do_reset(1'b0);
    run_to(4);
    step(1'b1, 16'h12AB, 4'h1);
    run_to(FR + 4);
    check("pre_rst_sel", 32'(digit_sel), 32'hB);
    check("pre_rst_an", 32'(an_n), 32'hE);
    check("pre_rst_dp", 32'(dp_n), 32'h0);
    do_reset(1'b0);
    for (int i = 0; i < RD; i++) begin
      step(1'b0, 16'h0, 4'h0);
      check("post_rst_an", 32'(an_n), (i < BC) ? 32'hF : 32'hE);
      check("post_rst_fs", 32'(frame_start), (i == 0) ? 32'h1 : 32'h0);
    end

    // Table: load during digit 1's slot, check each slot's drive phase of the next frame
    for (int i = 0; i < 6; i++) begin
      do_reset(vecs[i].lz);
      run_to(9);
      step(1'b1, vecs[i].v, vecs[i].dp);
      for (int k = 0; k < ND; k++) begin
        run_to(FR + k * RD + 4);
        check("vec_sel", 32'(digit_sel), 32'(vecs[i].sel[4*k +: 4]));
        check("vec_an", 32'(an_n), 32'(vecs[i].an[4*k +: 4]));
        check("vec_dpn", 32'(dp_n), 32'(vecs[i].dpn[k]));
      end
      run_to(2 * FR);
    end

    // Two strobes in one frame: only the later value may ever be shown
    do_reset(1'b0);
    run_to(4);
    step(1'b1, 16'h1111, 4'h0);
    run_to(19);
    step(1'b1, 16'h2222, 4'h0);
    run_to(FR - 1);
    for (int i = 0; i < FR; i++) begin
      step(1'b0, 16'h0, 4'h0);
      check("overwrite_sel", 32'(digit_sel), 32'h2);
    end

    // Strobe exactly on the wrap edge while another value is pending
    do_reset(1'b0);
    run_to(4);
    step(1'b1, 16'h1111, 4'h0);
    run_to(FR - 1);
    step(1'b1, 16'h3333, 4'h0);
    check("boundary_sel", 32'(digit_sel), 32'h3);
    check("boundary_fs", 32'(frame_start), 32'h1);
    for (int i = 0; i < 2 * FR - 1; i++) begin
      step(1'b0, 16'h0, 4'h0);
      check("boundary_hold", 32'(digit_sel), 32'h3);
    end

    // Randomized loads, with extra weight on strobes at the frame boundary
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(1'($urandom_range(1, 0)));
      for (int c = 0; c < 6 * FR; c++) begin
        logic [15:0] rv;
        logic        hit;
        rv = 16'($urandom);
        for (int k = 0; k < ND; k++) begin
          if ($urandom_range(1, 0) == 0) rv[4*k +: 4] = 4'h0;
        end
        hit = ($urandom_range(7, 0) == 0) || (((edge_n % FR) == 0) && ($urandom_range(1, 0) == 1));
        step(hit, rv, 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
